// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, bubble word, default boot PC and stride.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP                 = 32'h0000_0000;
  localparam logic [31:0] BOOT_PC_DEFAULT     = 32'h0000_1000;
  localparam logic [31:0] INSTR_BYTES_DEFAULT = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_skid_buffer.sv
// Two-entry in-order {instr,pc} queue: head is presented to decode, skid absorbs one overflow response.
module fetch_skid_buffer
  import fetch_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  logic [31:0] push_instr,
  input  logic [31:0] push_pc,
  input  logic        pop,
  input  logic        flush,
  output logic        head_valid,
  output logic [31:0] head_instr,
  output logic [31:0] head_pc,
  output logic        skid_valid
);

  logic        head_valid_q, head_valid_d;
  logic [31:0] head_instr_q, head_instr_d;
  logic [31:0] head_pc_q, head_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  always_comb begin
    head_valid_d = head_valid_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (flush) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (pop) begin
        head_valid_d = skid_valid_q;
        head_instr_d = skid_instr_q;
        head_pc_d    = skid_pc_q;
        skid_valid_d = 1'b0;
      end
      // A push lands in the head when it is free after the pop, otherwise in the skid.
      if (push) begin
        if (!head_valid_d) begin
          head_valid_d = 1'b1;
          head_instr_d = push_instr;
          head_pc_d    = push_pc;
        end else begin
          skid_valid_d = 1'b1;
          skid_instr_d = push_instr;
          skid_pc_d    = push_pc;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_valid_q <= 1'b0;
      head_instr_q <= NOP;
      head_pc_q    <= 32'h0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP;
      skid_pc_q    <= 32'h0;
    end else begin
      head_valid_q <= head_valid_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign head_valid = head_valid_q;
  assign head_instr = head_instr_q;
  assign head_pc    = head_pc_q;
  assign skid_valid = skid_valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, instruction-memory request FSM, redirect handling and the
// presentation queue feeding the fetch->decode register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] BOOT_PC     = BOOT_PC_DEFAULT,
  parameter logic [31:0] INSTR_BYTES = INSTR_BYTES_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        d_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] f_instr,
  output logic [31:0] f_pc,
  output logic        f_stall
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drop_addr_q, drop_addr_d;

  logic         head_valid, skid_valid;
  logic [31:0]  head_instr, head_pc;
  logic         push, pop, flush, issue_ok;
  logic [1:0]   occ_next;

  assign flush = redirect_valid;
  assign pop   = head_valid && !d_stall && !redirect_valid;
  assign push  = (state_q == ST_REQ) && imem_ack && !redirect_valid;

  // A new request may only go out if the skid will be empty after this edge,
  // guaranteeing a slot for its response.
  assign occ_next = {1'b0, head_valid} + {1'b0, skid_valid} + {1'b0, push} - {1'b0, pop};
  assign issue_ok = (occ_next <= 2'd1);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (redirect_valid || issue_ok) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (imem_ack) begin
          state_d = (redirect_valid || issue_ok) ? ST_REQ : ST_IDLE;
          if (!redirect_valid) pc_d = pc_q + INSTR_BYTES;
        end else if (redirect_valid) begin
          state_d     = ST_DROP;
          drop_addr_d = pc_q;
        end
      end
      ST_DROP: begin
        if (imem_ack) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
    if (redirect_valid) pc_d = word_align(redirect_pc);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= BOOT_PC;
      drop_addr_q <= BOOT_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  // A dropped request keeps its original address on the bus until the memory acks it.
  assign imem_req  = (state_q != ST_IDLE);
  assign imem_addr = (state_q == ST_DROP) ? drop_addr_q : pc_q;

  fetch_skid_buffer u_skid (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_instr (imem_rdata),
    .push_pc    (pc_q),
    .pop        (pop),
    .flush      (flush),
    .head_valid (head_valid),
    .head_instr (head_instr),
    .head_pc    (head_pc),
    .skid_valid (skid_valid)
  );

  assign f_stall = !head_valid;
  assign f_instr = head_valid ? head_instr : NOP;
  assign f_pc    = head_valid ? head_pc : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-programmable memory, an in-order stream model checked every
// cycle, and directed scenarios with hand-computed cycle-exact expectations.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic        d_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] f_instr;
  logic [31:0] f_pc;
  logic        f_stall;

  int n_checks = 0;
  int n_errs   = 0;
  int n_acks   = 0;

  int unsigned lat = 0;
  int unsigned wcnt;

  fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .d_stall        (d_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .f_instr        (f_instr),
    .f_pc           (f_pc),
    .f_stall        (f_stall)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory: ack arrives 'lat' cycles after the request first appears (lat=0 acks in the same cycle).
  always @(posedge clock or posedge reset) begin
    if (reset) wcnt <= 0;
    else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end
  assign imem_ack   = imem_req && (wcnt >= lat);
  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream model: decode must see BOOT_PC, +4, +4 ... restarting at each aligned redirect target,
  // each with its memory word, no gaps or repeats, a bubble right after a redirect, and holds under d_stall.
  logic [31:0] exp_pc;
  logic        exp_bubble, hold_prev, prev_req, prev_ack;
  logic [31:0] prev_addr;

  always @(negedge clock) begin
    if (reset) begin
      exp_pc     = 32'h0000_1000;
      exp_bubble = 1'b0;
      hold_prev  = 1'b0;
      prev_req   = 1'b0;
      prev_ack   = 1'b0;
      prev_addr  = 32'h0;
    end else begin
      if (f_stall) chk("m_bubble_instr", f_instr, 32'h0);
      else begin
        chk("m_pc", f_pc, exp_pc);
        chk("m_instr", f_instr, mem_word(exp_pc));
      end
      if (exp_bubble) chk("m_redirect_bubble", {31'b0, f_stall}, 32'd1);
      if (hold_prev) chk("m_hold", {31'b0, f_stall}, 32'd0);
      if (prev_req && !prev_ack) begin
        chk("m_req_held", {31'b0, imem_req}, 32'd1);
        chk("m_addr_stable", imem_addr, prev_addr);
      end
      if (imem_req) chk("m_addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
      if (imem_ack) n_acks++;
      hold_prev  = !f_stall && d_stall && !redirect_valid;
      exp_bubble = redirect_valid;
      if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
      else if (!f_stall && !d_stall) exp_pc = exp_pc + 32'd4;
      prev_req  = imem_req;
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
    end
  end

  logic        t2_stall [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [31:0] t2_addr  [10] = '{32'h0, 32'h1000, 32'h1000, 32'h1000, 32'h1000,
                                 32'h1004, 32'h1004, 32'h1004, 32'h1004, 32'h1008};
  logic [31:0] t1_pc    [3]  = '{32'h1000, 32'h1004, 32'h1008};
  logic [31:0] t3_pc    [4]  = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int unsigned l);
    reset          = 1'b1;
    d_stall        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    lat            = l;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  int a0;

  initial begin
    reset          = 1'b1;
    d_stall        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    tick();
    tick();
    chk("rst_f_stall", {31'b0, f_stall}, 32'd1);
    chk("rst_f_instr", f_instr, 32'h0);
    chk("rst_f_pc", f_pc, 32'h0);
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0000_1000);

    // zero-wait memory: back-to-back delivery from cycle 2
    do_reset(0);
    chk("t1_c0_req", {31'b0, imem_req}, 32'd0);
    tick();
    chk("t1_c1_req", {31'b0, imem_req}, 32'd1);
    chk("t1_c1_addr", imem_addr, 32'h1000);
    chk("t1_c1_stall", {31'b0, f_stall}, 32'd1);
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk("t1_stall", {31'b0, f_stall}, 32'd0);
      chk("t1_pc", f_pc, t1_pc[c-2]);
      if (c == 2) chk("t1_instr", f_instr, 32'hC0DE_1000);
    end

    // 3-cycle latency, then redirect to 0x2002 while the 0x1008 request is outstanding
    do_reset(3);
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (c == 10) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2002;
      end else begin
        redirect_valid = 1'b0;
      end
      #1;
      if (c <= 9) begin
        chk("t2_stall", {31'b0, f_stall}, {31'b0, t2_stall[c]});
        chk("t2_addr", imem_addr, t2_addr[c]);
      end
      if (c == 5) chk("t2_pc_a", f_pc, 32'h1000);
      if (c == 9) chk("t2_pc_b", f_pc, 32'h1004);
      if (c == 11) begin
        chk("t4_drop_req", {31'b0, imem_req}, 32'd1);
        chk("t4_drop_addr", imem_addr, 32'h1008);
      end
      if (c == 13) chk("t4_new_addr", imem_addr, 32'h2000);
      if (c == 17) begin
        chk("t4_stall", {31'b0, f_stall}, 32'd0);
        chk("t4_pc", f_pc, 32'h2000);
      end
    end

    // d_stall for 4 cycles with a valid head
    do_reset(0);
    tick();
    tick();
    d_stall = 1'b1;
    a0 = n_acks;
    chk("t3_c2_pc", f_pc, 32'h1000);
    for (int c = 3; c <= 5; c++) begin
      tick();
      chk("t3_frozen_pc", f_pc, 32'h1000);
      chk("t3_frozen_stall", {31'b0, f_stall}, 32'd0);
      chk("t3_no_req", {31'b0, imem_req}, 32'd0);
    end
    for (int c = 6; c <= 9; c++) begin
      tick();
      d_stall = 1'b0;
      if (c == 6) chk("t3_acks_in_stall", n_acks - a0, 32'd1);
      chk("t3_release_pc", f_pc, t3_pc[c-6]);
    end

    // redirect coinciding with ack and d_stall, then PC wrap
    do_reset(0);
    tick();
    tick();
    d_stall        = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3000;
    #1;
    chk("t5_ack_coincide", {31'b0, imem_ack}, 32'd1);
    chk("t5_c2_pc", f_pc, 32'h1000);
    tick();
    redirect_valid = 1'b0;
    chk("t5_bubble", {31'b0, f_stall}, 32'd1);
    chk("t5_addr", imem_addr, 32'h3000);
    tick();
    d_stall = 1'b0;
    chk("t5_pc_a", f_pc, 32'h3000);
    tick();
    chk("t5_pc_b", f_pc, 32'h3004);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    chk("t5_pc_c", f_pc, 32'h3008);
    tick();
    redirect_valid = 1'b0;
    chk("t6_wrap_bubble", {31'b0, f_stall}, 32'd1);
    chk("t6_wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("t6_wrap_pc_a", f_pc, 32'hFFFF_FFFC);
    tick();
    chk("t6_wrap_pc_b", f_pc, 32'h0000_0000);
    chk("t6_wrap_instr", f_instr, 32'hC0DE_0000);
    tick();
    chk("t6_wrap_pc_c", f_pc, 32'h0000_0004);

    // asynchronous reset in the middle of an outstanding request
    do_reset(1);
    tick();
    tick();
    tick();
    chk("t6_pre_stall", {31'b0, f_stall}, 32'd0);
    chk("t6_pre_req", {31'b0, imem_req}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_async_req", {31'b0, imem_req}, 32'd0);
    chk("t6_async_stall", {31'b0, f_stall}, 32'd1);
    chk("t6_async_addr", imem_addr, 32'h1000);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("t6_restart_addr", imem_addr, 32'h1000);
    chk("t6_restart_req", {31'b0, imem_req}, 32'd1);
    tick();
    tick();
    chk("t6_restart_pc", f_pc, 32'h1000);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
